vga_sync_gen: RTL and testbench

VGA timing generator that consumes the pixel-rate strobe produced by the team's clock divider. It steps horizontal and vertical counters once per pixel strobe and emits registered hsync/vsync, active-video and pixel coordinates. Its outputs feed the framebuffer reader and the DAC pins. It runs entirely in the system clock domain; the pixel rate arrives as an enable, not a derived clock.

---
 rtl/vga_sync_gen.sv | 153 +++++++++++++++
 tb/tb_vga_sync_gen.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator driven by a pixel-rate enable in the
// system clock domain. It steps horizontal and vertical counters once per
// pix_en strobe, then presents registered hsync/vsync, active, x/y and
// line/frame start pulses one clk after the strobe that consumed the pixel.
//
// Optional build macro VGA_PATTERN_EN: when defined, rgb carries an
// 8-bar colour test pattern. When undefined, rgb is tied to 12'h000.
module vga_sync_gen #(
    parameter int CNT_W    = 11,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic [11:0]      rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sized copies of the timing boundaries so every compare is CNT_W wide.
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // h_cnt/v_cnt hold the coordinates of the next pixel to present.
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;

    logic h_last;
    logic v_last;
    logic active_d;
    logic hs_on;
    logic vs_on;

    // Decode the pending pixel; the output registers sample this on pix_en.
    always_comb begin
        // NOTE: every always_comb output gets an unconditional assignment, so no latch can form.
        h_last   = (h_cnt == H_LAST);
        v_last   = (v_cnt == V_LAST);
        active_d = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
        hs_on    = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_on    = (v_cnt >= VS_START) && (v_cnt < VS_END);
    end

    // Raster counters: h steps per pixel, v steps on every h wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state uses non-blocking assignments, so every register samples pre-edge values.
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Registered outputs: load the pending pixel's decode; start pulses last one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            active      <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            hsync       <= hs_on ? HS_POL : ~HS_POL;
            vsync       <= vs_on ? VS_POL : ~VS_POL;
            active      <= active_d;
            x           <= h_cnt;
            y           <= v_cnt;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_PATTERN_EN
    // Bar width in pixels; guarded so very small timings still elaborate.
    localparam int               BAR_W    = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
    localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

    // bar_idx/bar_sub track the same pending pixel as h_cnt, avoiding a divider.
    logic [2:0]       bar_idx;
    logic [CNT_W-1:0] bar_sub;

    // Bar tracking: advance within the visible span, restart on every line wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_idx <= '0;
            bar_sub <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                bar_idx <= '0;
                bar_sub <= '0;
            end else if (h_cnt < H_ACT_C) begin
                if (bar_sub == BAR_LAST) begin
                    bar_sub <= '0;
                    bar_idx <= bar_idx + 1'b1;
                end else begin
                    bar_sub <= bar_sub + 1'b1;
                end
            end
        end
    end

    // Colour register: bar colour while visible, black in blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= 12'h000;
        end else if (pix_en) begin
            rgb <= active_d ? {{4{~bar_idx[2]}}, {4{~bar_idx[1]}}, {4{~bar_idx[0]}}}
                            : 12'h000;
        end
    end
`else
    assign rgb = 12'h000;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: drives a default-timing instance and a small-timing
// instance with fixed and random pix_en patterns and compares every output
// against a pixel-index reference model (h = n mod H_TOTAL, v = n / H_TOTAL).
`timescale 1ns/1ps
module tb_vga_sync_gen;

    typedef struct {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
        bit hpol, vpol;
    } timing_t;

    timing_t t_d = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    timing_t t_s = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        pix_en_s = 1'b0;

    logic        hsync, vsync, active, line_start, frame_start;
    logic [10:0] x, y;
    logic [11:0] rgb;
    logic        hsync_s, vsync_s, active_s, line_start_s, frame_start_s;
    logic [10:0] x_s, y_s;
    logic [11:0] rgb_s;

    int total = 0;
    int bad   = 0;

    // Model state: pixels consumed since reset, and whether the last edge had pix_en.
    int n_d = 0;
    int n_s = 0;
    bit pl_d = 1'b0;
    bit pl_s = 1'b0;

    always #5 clk = ~clk;

    vga_sync_gen #(.CNT_W(11)) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .hsync(hsync), .vsync(vsync), .active(active), .x(x), .y(y),
        .line_start(line_start), .frame_start(frame_start), .rgb(rgb)
    );

    vga_sync_gen #(
        .CNT_W(11), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en_s),
        .hsync(hsync_s), .vsync(vsync_s), .active(active_s), .x(x_s), .y(y_s),
        .line_start(line_start_s), .frame_start(frame_start_s), .rgb(rgb_s)
    );

    // Expected {hsync, vsync, active, x, y, line_start, frame_start, rgb}
    // after n pixels have been consumed.
    function automatic logic [38:0] model(timing_t t, int n, bit pulse);
        int ht, vt, p, h, v, k;
        logic a, hsv, vsv, ls, fs;
        logic [11:0] c;
        if (n == 0) return {~t.hpol, ~t.vpol, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 12'h000};
        ht  = t.ha + t.hfp + t.hs + t.hbp;
        vt  = t.va + t.vfp + t.vs + t.vbp;
        p   = n - 1;
        h   = p % ht;
        v   = (p / ht) % vt;
        a   = (h < t.ha) && (v < t.va);
        hsv = (h >= t.ha + t.hfp && h < t.ha + t.hfp + t.hs) ? t.hpol : ~t.hpol;
        vsv = (v >= t.va + t.vfp && v < t.va + t.vfp + t.vs) ? t.vpol : ~t.vpol;
        ls  = pulse && (h == 0);
        fs  = ls && (v == 0);
        c   = 12'h000;
        k   = 0;
`ifdef VGA_PATTERN_EN
        if (a && (t.ha % 8 == 0)) begin
            k = h / (t.ha / 8);
            c = {{4{~k[2]}}, {4{~k[1]}}, {4{~k[0]}}};
        end
`endif
        return {hsv, vsv, a, 11'(h), 11'(v), ls, fs, c};
    endfunction

    function automatic logic [38:0] obs_d();
        return {hsync, vsync, active, x, y, line_start, frame_start, rgb};
    endfunction

    // The small instance is too narrow for the bar pattern, so its rgb is not compared.
    function automatic logic [38:0] obs_s();
        return {hsync_s, vsync_s, active_s, x_s, y_s, line_start_s, frame_start_s, 12'h000};
    endfunction

    // One clk: drive enables, take the edge, update the model, settle 1ns past the edge.
    task automatic tick(input bit en_d, input bit en_s);
        pix_en   = en_d;
        pix_en_s = en_s;
        @(posedge clk);
        if (rst_n) begin
            if (en_d) n_d++;
            if (en_s) n_s++;
            pl_d = en_d;
            pl_s = en_s;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        pix_en   = 1'b0;
        pix_en_s = 1'b0;
        n_d = 0; n_s = 0; pl_d = 1'b0; pl_s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [38:0] e;
        rst_n = 1'b0;
        n_d = 0; n_s = 0; pl_d = 1'b0; pl_s = 1'b0;
        repeat (2) tick(1'b1, 1'b1);
        e = model(t_d, 0, 1'b0);
        total++;
        if (obs_d() !== e) begin bad++; $display("FAIL reset_d got=%h exp=%h", obs_d(), e); end
        e = model(t_s, 0, 1'b0);
        total++;
        if (obs_s() !== e) begin bad++; $display("FAIL reset_s got=%h exp=%h", obs_s(), e); end
        rst_n = 1'b1;
        repeat (3) begin
            tick(1'b0, 1'b0);
            e = model(t_d, n_d, pl_d);
            total++;
            if (obs_d() !== e) begin bad++; $display("FAIL reset_idle got=%h exp=%h", obs_d(), e); end
        end
    endtask

    task automatic test_first_pixel();
        logic [38:0] e;
        tick(1'b1, 1'b0);
        total++;
        if ({frame_start, line_start, active, x, y} !== {1'b1, 1'b1, 1'b1, 11'd0, 11'd0}) begin
            bad++;
            $display("FAIL first_pixel got fs=%b ls=%b act=%b x=%0d y=%0d exp fs=1 ls=1 act=1 x=0 y=0",
                     frame_start, line_start, active, x, y);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            e = model(t_d, n_d, pl_d);
            total++;
            if (obs_d() !== e) begin bad++; $display("FAIL first_hold got=%h exp=%h", obs_d(), e); end
        end
    endtask

    task automatic test_line0();
        logic [38:0] e;
        int act_cnt, hs_cnt, hs_first, hs_last, ls_prev, ls_gap_bad;
        apply_reset();
        act_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; ls_prev = -1; ls_gap_bad = 0;
        for (int p = 0; p <= 1600; p++) begin
            tick(1'b1, 1'b0);
            e = model(t_d, n_d, pl_d);
            total++;
            if (obs_d() !== e) begin bad++; $display("FAIL line0 p=%0d got=%h exp=%h", p, obs_d(), e); end
            if (y == 11'd0) begin
                if (active) act_cnt++;
                if (!hsync) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(x);
                    hs_last = int'(x);
                end
            end
            if (line_start) begin
                if (ls_prev >= 0 && p - ls_prev != 800) ls_gap_bad++;
                ls_prev = p;
            end
            repeat (3) tick(1'b0, 1'b0);
        end
        total++;
        if (act_cnt != 640) begin bad++; $display("FAIL line0_active got=%0d exp=640", act_cnt); end
        total++;
        if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
            bad++;
            $display("FAIL line0_hsync got cnt=%0d first=%0d last=%0d exp cnt=96 first=656 last=751",
                     hs_cnt, hs_first, hs_last);
        end
        total++;
        if (ls_gap_bad != 0 || ls_prev != 1600) begin
            bad++;
            $display("FAIL line0_linestart got bad_gaps=%0d last=%0d exp 0 and 1600", ls_gap_bad, ls_prev);
        end
    endtask

    task automatic test_small_frame();
        logic [38:0] e;
        int hs_hi, hs_badx, vs_lo, vs_bady, act_cnt, fs_prev, fs_gap_bad, fs_seen;
        apply_reset();
        hs_hi = 0; hs_badx = 0; vs_lo = 0; vs_bady = 0; act_cnt = 0;
        fs_prev = -1; fs_gap_bad = 0; fs_seen = 0;
        for (int c = 0; c <= 144; c++) begin
            tick(1'b0, 1'b1);
            e = model(t_s, n_s, pl_s);
            total++;
            if (obs_s() !== e) begin bad++; $display("FAIL small c=%0d got=%h exp=%h", c, obs_s(), e); end
            if (c < 96) begin
                if (hsync_s) begin
                    hs_hi++;
                    if (x_s != 11'd5 && x_s != 11'd6) hs_badx++;
                end
                if (!vsync_s) begin
                    vs_lo++;
                    if (y_s != 11'd4) vs_bady++;
                end
                if (active_s) act_cnt++;
            end
            if (frame_start_s) begin
                fs_seen++;
                if (fs_prev >= 0 && c - fs_prev != 48) fs_gap_bad++;
                fs_prev = c;
            end
        end
        total++;
        if (hs_hi != 24 || hs_badx != 0) begin
            bad++; $display("FAIL small_hsync got hi=%0d badx=%0d exp hi=24 badx=0", hs_hi, hs_badx);
        end
        total++;
        if (vs_lo != 16 || vs_bady != 0) begin
            bad++; $display("FAIL small_vsync got lo=%0d bady=%0d exp lo=16 bady=0", vs_lo, vs_bady);
        end
        total++;
        if (act_cnt != 24) begin bad++; $display("FAIL small_active got=%0d exp=24", act_cnt); end
        total++;
        if (fs_seen != 4 || fs_gap_bad != 0) begin
            bad++; $display("FAIL small_frame got seen=%0d bad_gaps=%0d exp seen=4 bad_gaps=0", fs_seen, fs_gap_bad);
        end
    endtask

    task automatic test_random();
        logic [38:0] e;
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1));
            e = model(t_d, n_d, pl_d);
            total++;
            if (obs_d() !== e) begin bad++; $display("FAIL rand_d i=%0d got=%h exp=%h", i, obs_d(), e); end
            e = model(t_s, n_s, pl_s);
            total++;
            if (obs_s() !== e) begin bad++; $display("FAIL rand_s i=%0d got=%h exp=%h", i, obs_s(), e); end
        end
    endtask

    task automatic test_hold();
        logic [38:0] e;
        apply_reset();
        repeat (301) tick(1'b1, 1'b0);
        total++;
        if (x !== 11'd300) begin bad++; $display("FAIL hold_start got x=%0d exp=300", x); end
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b0);
            e = model(t_d, n_d, pl_d);
            total++;
            if (obs_d() !== e) begin bad++; $display("FAIL hold i=%0d got=%h exp=%h", i, obs_d(), e); end
        end
        tick(1'b1, 1'b0);
        total++;
        if (x !== 11'd301 || y !== 11'd0) begin bad++; $display("FAIL hold_resume got x=%0d y=%0d exp x=301 y=0", x, y); end
    endtask

    task automatic test_reset_mid_line();
        logic [38:0] e;
        repeat (9) tick(1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        n_d = 0; n_s = 0; pl_d = 1'b0; pl_s = 1'b0;
        #1;
        total++;
        if ({hsync, active, x} !== {1'b1, 1'b0, 11'd0}) begin
            bad++; $display("FAIL async_reset got hs=%b act=%b x=%0d exp hs=1 act=0 x=0", hsync, active, x);
        end
        e = model(t_s, 0, 1'b0);
        total++;
        if (obs_s() !== e) begin bad++; $display("FAIL async_reset_s got=%h exp=%h", obs_s(), e); end
        tick(1'b1, 1'b1);
        e = model(t_d, 0, 1'b0);
        total++;
        if (obs_d() !== e) begin bad++; $display("FAIL reset_held got=%h exp=%h", obs_d(), e); end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b1);
            e = model(t_d, n_d, pl_d);
            total++;
            if (obs_d() !== e) begin bad++; $display("FAIL restart_d i=%0d got=%h exp=%h", i, obs_d(), e); end
            e = model(t_s, n_s, pl_s);
            total++;
            if (obs_s() !== e) begin bad++; $display("FAIL restart_s i=%0d got=%h exp=%h", i, obs_s(), e); end
        end
    endtask

    task automatic test_rgb();
        logic [11:0] c_bar0, c_bar1, c_bar7;
`ifdef VGA_PATTERN_EN
        c_bar0 = 12'hFFF; c_bar1 = 12'hFF0; c_bar7 = 12'h000;
`else
        c_bar0 = 12'h000; c_bar1 = 12'h000; c_bar7 = 12'h000;
`endif
        apply_reset();
        for (int p = 0; p < 720; p++) begin
            tick(1'b1, 1'b0);
            if (p == 0 || p == 79) begin
                total++;
                if (rgb !== c_bar0) begin bad++; $display("FAIL rgb_bar0 x=%0d got=%h exp=%h", p, rgb, c_bar0); end
            end else if (p == 80 || p == 159) begin
                total++;
                if (rgb !== c_bar1) begin bad++; $display("FAIL rgb_bar1 x=%0d got=%h exp=%h", p, rgb, c_bar1); end
            end else if (p == 560 || p == 639) begin
                total++;
                if (rgb !== c_bar7) begin bad++; $display("FAIL rgb_bar7 x=%0d got=%h exp=%h", p, rgb, c_bar7); end
            end else if (p == 700) begin
                total++;
                if (rgb !== 12'h000) begin bad++; $display("FAIL rgb_blank x=%0d got=%h exp=000", p, rgb); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_line0();
        test_small_frame();
        test_random();
        test_hold();
        test_reset_mid_line();
        test_rgb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
